// File: rtl/v0stkseq.sv
// ---------------------------------------------------------------------------
// v0stkseq -- multi-cycle sequencer for the v0 stack operations PSH, POP,
// PSM and POM. Walks a register bitmap one register at a time and issues one
// 32-bit data-memory access per register. It reports the final stack pointer
// and a status code.
//
// Optional feature (compile-time macro V0_STKSEQ_LIMIT_EN): adds the stklim
// input. A push whose target address would fall below stklim, or would wrap
// below zero, ends the operation with err=LIM.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start/op/map/sp  operation request; sampled when start && ready
//   ready, done      idle indicator, one-cycle completion pulse
//   spout, err       final stack pointer / status (00 OK, 01 ALN, 10 BUS, 11 LIM)
//   rf_ra/rf_rd      register-file read port (combinational read data)
//   rf_we/wa/wd      register-file write port (pops only)
//   mem_*            data-memory request/acknowledge port
//   stklim           lowest legal stack address (V0_STKSEQ_LIMIT_EN only)
//   dbg_state        current FSM state (00 IDLE, 01 SEL, 10 XFER, 11 DONE)
//
// Handshakes:
//   start/ready: a request is taken on a rising edge where start=1 and
//   ready=1; start at any other time is ignored, never queued. done is a
//   one-cycle pulse with no back-pressure. mem_req stays high with mem_we,
//   mem_adr and mem_wd frozen until a rising edge sees mem_ack=1; mem_err is
//   only meaningful in that same cycle.
// ---------------------------------------------------------------------------
module v0stkseq #(
  parameter int NREG  = 16,
  parameter int RBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [NREG-1:0]  map,
  input  logic [31:0]      sp,
  output logic             ready,
  output logic             done,
  output logic [31:0]      spout,
  output logic [1:0]       err,
  output logic [RBITS-1:0] rf_ra,
  input  logic [31:0]      rf_rd,
  output logic             rf_we,
  output logic [RBITS-1:0] rf_wa,
  output logic [31:0]      rf_wd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  input  logic             mem_ack,
  input  logic             mem_err,
`ifdef V0_STKSEQ_LIMIT_EN
  input  logic [31:0]      stklim,
`endif
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SEL  = 2'b01;
  localparam logic [1:0] S_XFER = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_ALN = 2'b01;
  localparam logic [1:0] ERR_BUS = 2'b10;
`ifdef V0_STKSEQ_LIMIT_EN
  localparam logic [1:0] ERR_LIM = 2'b11;
`endif

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  // Highest set bit: pushes store the highest register first so that a
  // later multi-pop (lowest first) restores registers in mirror order.
  function automatic logic [RBITS-1:0] hi_bit(input logic [NREG-1:0] m);
    logic [RBITS-1:0] id;
    id = '0;
    for (int i = 0; i < NREG; i++) begin
      if (m[i]) id = RBITS'(i);
    end
    return id;
  endfunction

  function automatic logic [RBITS-1:0] lo_bit(input logic [NREG-1:0] m);
    logic [RBITS-1:0] id;
    id = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) id = RBITS'(i);
    end
    return id;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [NREG-1:0]  mask_q, mask_d;
  logic [31:0]      sp_q, sp_d;
  logic             push_q, push_d;
  logic [RBITS-1:0] cur_q, cur_d;
  logic [31:0]      mem_adr_q, mem_adr_d;
  logic [31:0]      mem_wd_q, mem_wd_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      spout_q, spout_d;
  logic [1:0]       err_q, err_d;

  logic [NREG-1:0]  mask_in;   // mask implied by the incoming request
  logic [RBITS-1:0] sel_id;    // register picked in SEL
  logic [NREG-1:0]  mask_clr;  // mask with the in-flight register removed
  logic [31:0]      sp_dec;
  logic [31:0]      sp_nxt;    // sp after a successful access
  logic             ack_ok;

  // Single-register ops decode the low ID bits into a one-hot mask so that
  // both op families share the bitmap walk.
  assign mask_in  = op[1] ? map : (ONE << map[RBITS-1:0]);
  assign sel_id   = push_q ? hi_bit(mask_q) : lo_bit(mask_q);
  assign mask_clr = mask_q & ~(ONE << cur_q);
  assign sp_dec   = sp_q - 32'd4;
  // A push's new sp equals the address just stored to.
  assign sp_nxt   = push_q ? mem_adr_q : (sp_q + 32'd4);
  assign ack_ok   = mem_ack && !mem_err;

`ifdef V0_STKSEQ_LIMIT_EN
  logic lim_hit;
  // sp < 4 means sp-4 wraps past zero, which is always illegal.
  assign lim_hit = (sp_q < 32'd4) || (sp_dec < stklim);
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      sp_q      <= '0;
      push_q    <= 1'b0;
      cur_q     <= '0;
      mem_adr_q <= '0;
      mem_wd_q  <= '0;
      mem_we_q  <= 1'b0;
      spout_q   <= '0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      sp_q      <= sp_d;
      push_q    <= push_d;
      cur_q     <= cur_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
      mem_we_q  <= mem_we_d;
      spout_q   <= spout_d;
      err_q     <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sp[1:0] != 2'b00)  state_d = S_DONE;
          else if (mask_in == '0) state_d = S_DONE;
          else                   state_d = S_SEL;
        end
      end
      S_SEL: begin
        state_d = S_XFER;
`ifdef V0_STKSEQ_LIMIT_EN
        if (push_q && lim_hit) state_d = S_DONE;
`endif
      end
      S_XFER: begin
        if (mem_ack) begin
          if (mem_err)            state_d = S_DONE;
          else if (mask_clr == '0) state_d = S_DONE;
          else                    state_d = S_SEL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    mask_d    = mask_q;
    sp_d      = sp_q;
    push_d    = push_q;
    cur_d     = cur_q;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    mem_we_d  = mem_we_q;
    spout_d   = spout_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = mask_in;
          sp_d   = sp;
          push_d = ~op[0];
          if (sp[1:0] != 2'b00) begin
            mask_d  = '0;
            spout_d = sp;
            err_d   = ERR_ALN;
          end else if (mask_in == '0) begin
            spout_d = sp;
            err_d   = ERR_OK;
          end
        end
      end
      S_SEL: begin
        cur_d     = sel_id;
        mem_we_d  = push_q;
        mem_adr_d = push_q ? sp_dec : sp_q;
        if (push_q) mem_wd_d = rf_rd;
`ifdef V0_STKSEQ_LIMIT_EN
        if (push_q && lim_hit) begin
          mask_d  = '0;
          spout_d = sp_q;
          err_d   = ERR_LIM;
        end
`endif
      end
      S_XFER: begin
        if (mem_ack) begin
          if (mem_err) begin
            // Faulting access leaves sp untouched; remaining bits dropped.
            mask_d  = '0;
            spout_d = sp_q;
            err_d   = ERR_BUS;
          end else begin
            mask_d = mask_clr;
            sp_d   = sp_nxt;
            if (mask_clr == '0) begin
              spout_d = sp_nxt;
              err_d   = ERR_OK;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ready     = (state_q == S_IDLE);
    done      = (state_q == S_DONE);
    mem_req   = (state_q == S_XFER);
    rf_ra     = (state_q == S_SEL) ? sel_id : '0;
    rf_we     = (state_q == S_XFER) && ack_ok && !push_q;
    rf_wa     = cur_q;
    rf_wd     = rf_we ? mem_rd : '0;
    mem_we    = mem_we_q;
    mem_adr   = mem_adr_q;
    mem_wd    = mem_wd_q;
    spout     = spout_q;
    err       = err_q;
    dbg_state = state_q;
  end

endmodule
